// File: rtl/fetch_decode.sv
// fetch_decode: front-end sequencer for the multi-cycle core.
// Holds the PC, fetches from a synchronous-read instruction memory, owns the
// 32x32 register file and steps a fixed FETCH/DECODE/EXEC/WB instruction cycle.
// Optional feature macro: FETCH_DECODE_HALT_EN (opcode 63 halts the core).
module fetch_decode #(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  output logic [31:0]        reg1,
  output logic [31:0]        reg2,
  input  logic [4:0]         wra,
  input  logic [31:0]        result,
  input  logic [31:0]        nextpc,
  output logic [1:0]         phase,
  output logic               retire,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic        retire_q, retire_d;
  logic        rf_we;
  logic [31:0] rf_q [0:31];
  logic [4:0]  rs_sel;
  logic [4:0]  rt_sel;
`ifdef FETCH_DECODE_HALT_EN
  logic        halted_q, halted_d;
`endif

  // Next-state, PC, instruction latch and writeback enable for the 4-phase cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
`ifdef FETCH_DECODE_HALT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (run) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ins_d   = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
`ifdef FETCH_DECODE_HALT_EN
        if (ins_q[31:26] == 6'd63) begin
          // Halt: no writeback, PC frozen, no retire pulse.
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          rf_we    = (wra != 5'd0);
          pc_d     = nextpc;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
`else
        rf_we    = (wra != 5'd0);
        pc_d     = nextpc;
        retire_d = 1'b1;
        state_d  = S_FETCH;
`endif
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers and register file; reset aborts any writeback in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ins_q    <= 32'd0;
      retire_q <= 1'b0;
`ifdef FETCH_DECODE_HALT_EN
      halted_q <= 1'b0;
`endif
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      retire_q <= retire_d;
`ifdef FETCH_DECODE_HALT_EN
      halted_q <= halted_d;
`endif
      if (rf_we) begin
        rf_q[wra] <= result;
      end
    end
  end

  // Output decode: ins is a bubble outside EXEC/WB; r0 always reads zero.
  always_comb begin
    if ((state_q == S_EXEC) || (state_q == S_WB)) begin
      ins = ins_q;
    end else begin
      ins = 32'd0;
    end
    rs_sel = ins[25:21];
    rt_sel = ins[20:16];
    if (rs_sel == 5'd0) begin
      reg1 = 32'd0;
    end else begin
      reg1 = rf_q[rs_sel];
    end
    if (rt_sel == 5'd0) begin
      reg2 = 32'd0;
    end else begin
      reg2 = rf_q[rt_sel];
    end
    if (state_q == S_HALT) begin
      phase = 2'd3;
    end else begin
      phase = state_q[1:0];
    end
  end

  assign imem_addr = pc_q[IMEM_AW-1:0];
  assign pc        = pc_q;
  assign retire    = retire_q;
`ifdef FETCH_DECODE_HALT_EN
  assign halted    = halted_q;
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Directed testbench for fetch_decode: the bench plays instruction memory and
// the execute stage, driving wra/result/nextpc by hand for each instruction.
module tb_fetch_decode;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wra;
  logic [31:0] result;
  logic [31:0] nextpc;
  logic [1:0]  phase;
  logic        retire;
  logic        halted;

  logic [31:0] imem [0:255];
  int          vectors;
  int          miscompares;
  logic        retire_seen;

  fetch_decode #(.IMEM_AW(8), .RESET_PC(32'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ins       (ins),
    .pc        (pc),
    .reg1      (reg1),
    .reg2      (reg2),
    .wra       (wra),
    .result    (result),
    .nextpc    (nextpc),
    .phase     (phase),
    .retire    (retire),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory model.
  always @(posedge clk) imem_data <= imem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    imem[0]  = 32'h0401_0005;  // addi r1,r0,5
    imem[1]  = 32'h0020_0000;  // reads rs=r1
    imem[16] = 32'h0001_0000;  // reads rs=r0, rt=r1
    rst = 1'b1; run = 1'b0; wra = 5'd0; result = 32'd0; nextpc = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_reg1", reg1, 32'd0);
    chk("rst_reg2", reg2, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);

    // Idle with run=0
    retire_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      retire_seen = retire_seen | retire;
      chk("idle_phase", {30'd0, phase}, 32'd0);
    end
    chk("idle_pc", pc, 32'd0);
    chk("idle_retire", {31'd0, retire_seen}, 32'd0);

    // Instruction A at pc 0: addi r1,r0,5
    run = 1'b1; wra = 5'd1; result = 32'd5; nextpc = 32'd1;
    tick();
    chk("a_dec_phase", {30'd0, phase}, 32'd1);
    chk("a_dec_ins", ins, 32'd0);
    run = 1'b0;  // dropping run mid-instruction must not stall it
    tick();
    chk("a_exec_phase", {30'd0, phase}, 32'd2);
    chk("a_exec_ins", ins, 32'h0401_0005);
    chk("a_exec_reg2", reg2, 32'd0);
    tick();
    chk("a_wb_phase", {30'd0, phase}, 32'd3);
    chk("a_wb_retire", {31'd0, retire}, 32'd0);
    chk("a_wb_reg2_old", reg2, 32'd0);
    tick();
    chk("a_fetch_phase", {30'd0, phase}, 32'd0);
    chk("a_pc", pc, 32'd1);
    chk("a_imem_addr", {24'd0, imem_addr}, 32'd1);
    chk("a_retire", {31'd0, retire}, 32'd1);
    tick();
    chk("a_retire_once", {31'd0, retire}, 32'd0);
    chk("a_hold_phase", {30'd0, phase}, 32'd0);

    // Instruction B at pc 1: read r1, write r0, branch to 0x10
    run = 1'b1;
    tick(); tick();
    chk("b_exec_ins", ins, 32'h0020_0000);
    chk("b_reg1", reg1, 32'd5);
    run = 1'b0; wra = 5'd0; result = 32'hDEAD_BEEF; nextpc = 32'h10;
    tick(); tick();
    chk("br_pc", pc, 32'h10);
    chk("br_imem_addr", {24'd0, imem_addr}, 32'h10);
    chk("br_fetch_ins", ins, 32'd0);
    chk("br_retire", {31'd0, retire}, 32'd1);

    // Instruction C at pc 0x10: r0 still zero, reset during WB
    run = 1'b1;
    tick();
    chk("c_dec_ins", ins, 32'd0);
    tick();
    chk("c_exec_ins", ins, 32'h0001_0000);
    chk("c_reg1_r0", reg1, 32'd0);
    chk("c_reg2_r1", reg2, 32'd5);
    run = 1'b0; wra = 5'd3; result = 32'd7; nextpc = 32'h11;
    tick();
    chk("c_wb_phase", {30'd0, phase}, 32'd3);
    rst = 1'b1;
    tick();
    chk("wbrst_phase", {30'd0, phase}, 32'd0);
    chk("wbrst_pc", pc, 32'd0);
    chk("wbrst_retire", {31'd0, retire}, 32'd0);
    rst = 1'b0;

    // Instruction D at pc 0: confirm r3 not written and r1 cleared by reset
    imem[0] = 32'h0061_0000;
    imem[1] = 32'hFC00_0000;
    run = 1'b1; wra = 5'd0; result = 32'd0; nextpc = 32'd1;
    tick(); tick();
    chk("d_exec_ins", ins, 32'h0061_0000);
    chk("d_reg1_r3", reg1, 32'd0);
    chk("d_reg2_r1", reg2, 32'd0);
    run = 1'b0;
    tick(); tick();
    chk("d_pc", pc, 32'd1);

    // Instruction E at pc 1: opcode 63
    run = 1'b1; wra = 5'd2; result = 32'h1234; nextpc = 32'd2;
    tick(); tick();
    chk("e_exec_ins", ins, 32'hFC00_0000);
    run = 1'b0;
    tick();
    chk("e_wb_phase", {30'd0, phase}, 32'd3);
    chk("e_wb_halted", {31'd0, halted}, 32'd0);
    tick();
`ifdef FETCH_DECODE_HALT_EN
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'd1);
    chk("halt_phase", {30'd0, phase}, 32'd3);
    chk("halt_retire", {31'd0, retire}, 32'd0);
    chk("halt_ins", ins, 32'd0);
    run = 1'b1;
    retire_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      retire_seen = retire_seen | retire;
      chk("halt_stay_phase", {30'd0, phase}, 32'd3);
    end
    chk("halt_stay_retire", {31'd0, retire_seen}, 32'd0);
    chk("halt_stay_pc", pc, 32'd1);
`else
    chk("op63_halted", {31'd0, halted}, 32'd0);
    chk("op63_pc", pc, 32'd2);
    chk("op63_phase", {30'd0, phase}, 32'd0);
    chk("op63_retire", {31'd0, retire}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
